tsr_multi: RTL and testbench



---
 rtl/tsr_multi.sv | 100 ++++++++++
 tb/tb_tsr_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsr_multi.sv
// Multi-flag timer status register: N event flags with configurable software clear,
// per-flag overrun capture, interrupt enables and a registered interrupt request.
module tsr_multi #(
    parameter int NUM_FLAGS  = 2,
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 3,
    parameter int STS_INDEX  = 2,
    parameter int OVR_INDEX  = 3,
    parameter int IE_INDEX   = 4,
    parameter int CLEAR_MODE = 0
) (
    input  logic                 tsrm_clk,
    input  logic                 tsrm_reset,
    input  logic                 tsrm_sel,
    input  logic                 tsrm_write,
    input  logic                 tsrm_enable,
    input  logic                 tsrm_ready,
    input  logic [SEL_W-1:0]     tsrm_selected_reg,
    input  logic [DATA_W-1:0]    tsrm_wdata,
    input  logic [NUM_FLAGS-1:0] tsrm_evt,
    output logic [DATA_W-1:0]    tsrm_rdata,
    output logic [NUM_FLAGS-1:0] tsrm_flag,
    output logic [NUM_FLAGS-1:0] tsrm_evt_ack,
    output logic                 tsrm_irq
);

    logic                 wr_acc, rd_acc;
    logic                 sts_sel, ovr_sel, ie_sel;
    logic [NUM_FLAGS-1:0] wdata_flags, clr;
    logic [NUM_FLAGS-1:0] sts_q, ovr_q, ie_q;
    logic [NUM_FLAGS-1:0] sts_clr, ovr_clr, ovr_set;
    logic [NUM_FLAGS-1:0] sts_next, ovr_next, ie_next;
    logic [DATA_W-1:0]    rdata_mux;
    logic                 unused_bits;

    assign wr_acc = tsrm_sel &  tsrm_write & tsrm_enable & tsrm_ready;
    assign rd_acc = tsrm_sel & ~tsrm_write & tsrm_enable & tsrm_ready;

    // Select indices beyond the decoder width leave that register unaddressable.
    if (STS_INDEX < SEL_W) begin : g_sts_sel
        assign sts_sel = tsrm_selected_reg[STS_INDEX];
    end else begin : g_sts_none
        assign sts_sel = 1'b0;
    end

    if (OVR_INDEX < SEL_W) begin : g_ovr_sel
        assign ovr_sel = tsrm_selected_reg[OVR_INDEX];
    end else begin : g_ovr_none
        assign ovr_sel = 1'b0;
    end

    if (IE_INDEX < SEL_W) begin : g_ie_sel
        assign ie_sel = tsrm_selected_reg[IE_INDEX];
    end else begin : g_ie_none
        assign ie_sel = 1'b0;
    end

    assign unused_bits = ^{tsrm_selected_reg, tsrm_wdata};

    assign wdata_flags = tsrm_wdata[NUM_FLAGS-1:0];
    assign clr         = (CLEAR_MODE != 0) ? wdata_flags : ~wdata_flags;

    assign sts_clr = {NUM_FLAGS{wr_acc & sts_sel}} & clr;
    assign ovr_clr = {NUM_FLAGS{wr_acc & ovr_sel}} & clr;

    // Events beat clears so nothing is lost; an overrun needs a still-pending flag.
    assign sts_next = tsrm_evt | (sts_q & ~sts_clr);
    assign ovr_set  = tsrm_evt & sts_q & ~sts_clr;
    assign ovr_next = ovr_set | (ovr_q & ~ovr_clr);
    assign ie_next  = (wr_acc & ie_sel) ? wdata_flags : ie_q;

    always_ff @(posedge tsrm_clk) begin
        if (tsrm_reset) begin
            sts_q        <= '0;
            ovr_q        <= '0;
            ie_q         <= '0;
            tsrm_evt_ack <= '0;
            tsrm_irq     <= 1'b0;
        end else begin
            sts_q        <= sts_next;
            ovr_q        <= ovr_next;
            ie_q         <= ie_next;
            tsrm_evt_ack <= tsrm_evt;
            tsrm_irq     <= |(sts_next & ie_next);
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (rd_acc) begin
            if (sts_sel) rdata_mux[NUM_FLAGS-1:0] = rdata_mux[NUM_FLAGS-1:0] | sts_q;
            if (ovr_sel) rdata_mux[NUM_FLAGS-1:0] = rdata_mux[NUM_FLAGS-1:0] | ovr_q;
            if (ie_sel)  rdata_mux[NUM_FLAGS-1:0] = rdata_mux[NUM_FLAGS-1:0] | ie_q;
        end
    end

    assign tsrm_rdata = rdata_mux;
    assign tsrm_flag  = sts_q;

endmodule

// File: tb/tb_tsr_multi.sv
// Directed bench for tsr_multi: two 2-flag instances (clear modes 0 and 1) and a
// 5-flag instance share one bus; each has its own event input.
module tb_tsr_multi;

    localparam logic [4:0] R_STS = 5'b00100;
    localparam logic [4:0] R_OVR = 5'b01000;
    localparam logic [4:0] R_IE  = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel, write, enable, ready;
    logic [4:0] selected_reg;
    logic [7:0] wdata;
    logic [1:0] evt0, evt1;
    logic [4:0] evt5;

    logic [7:0] rdata0, rdata1, rdata5;
    logic [1:0] flag0, flag1, ack0, ack1;
    logic [4:0] flag5, ack5;
    logic       irq0, irq1, irq5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tsr_multi #(.NUM_FLAGS(2), .DATA_W(8), .SEL_W(5), .STS_INDEX(2), .OVR_INDEX(3),
                .IE_INDEX(4), .CLEAR_MODE(0)) u_m0 (
        .tsrm_clk(clk), .tsrm_reset(reset), .tsrm_sel(sel), .tsrm_write(write),
        .tsrm_enable(enable), .tsrm_ready(ready), .tsrm_selected_reg(selected_reg),
        .tsrm_wdata(wdata), .tsrm_evt(evt0), .tsrm_rdata(rdata0), .tsrm_flag(flag0),
        .tsrm_evt_ack(ack0), .tsrm_irq(irq0));

    tsr_multi #(.NUM_FLAGS(2), .DATA_W(8), .SEL_W(5), .STS_INDEX(2), .OVR_INDEX(3),
                .IE_INDEX(4), .CLEAR_MODE(1)) u_m1 (
        .tsrm_clk(clk), .tsrm_reset(reset), .tsrm_sel(sel), .tsrm_write(write),
        .tsrm_enable(enable), .tsrm_ready(ready), .tsrm_selected_reg(selected_reg),
        .tsrm_wdata(wdata), .tsrm_evt(evt1), .tsrm_rdata(rdata1), .tsrm_flag(flag1),
        .tsrm_evt_ack(ack1), .tsrm_irq(irq1));

    tsr_multi #(.NUM_FLAGS(5), .DATA_W(8), .SEL_W(5), .STS_INDEX(2), .OVR_INDEX(3),
                .IE_INDEX(4), .CLEAR_MODE(0)) u_w5 (
        .tsrm_clk(clk), .tsrm_reset(reset), .tsrm_sel(sel), .tsrm_write(write),
        .tsrm_enable(enable), .tsrm_ready(ready), .tsrm_selected_reg(selected_reg),
        .tsrm_wdata(wdata), .tsrm_evt(evt5), .tsrm_rdata(rdata5), .tsrm_flag(flag5),
        .tsrm_evt_ack(ack5), .tsrm_irq(irq5));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        sel = 1'b0; write = 1'b0; enable = 1'b0; ready = 1'b0;
        selected_reg = '0; wdata = '0;
    endtask

    task automatic do_reset;
        idle();
        evt0 = '0; evt1 = '0; evt5 = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_wr_q(input logic [4:0] rs, input logic [7:0] d,
                            input logic s, input logic e, input logic r);
        sel = s; write = 1'b1; enable = e; ready = r; selected_reg = rs; wdata = d;
        tick();
        idle();
    endtask

    task automatic bus_wr(input logic [4:0] rs, input logic [7:0] d);
        bus_wr_q(rs, d, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic rd_set(input logic [4:0] rs, input logic r);
        sel = 1'b1; write = 1'b0; enable = 1'b1; ready = r; selected_reg = rs; wdata = '0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        evt0 = 2'b11; evt1 = 2'b11; evt5 = 5'b11111;
        bus_wr(R_STS | R_IE, 8'hFF);
        tick();
        reset = 1'b0;
        evt0 = '0; evt1 = '0; evt5 = '0;
        checks++; if (flag0 !== 2'b00) begin errors++; $display("FAIL reset_flag0 got %b exp 00", flag0); end
        checks++; if (flag1 !== 2'b00) begin errors++; $display("FAIL reset_flag1 got %b exp 00", flag1); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq0 got %b exp 0", irq0); end
        checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL reset_ack0 got %b exp 00", ack0); end
        rd_set(R_STS | R_OVR | R_IE, 1'b1);
        checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata0 got %h exp 00", rdata0); end
        checks++; if (rdata5 !== 8'h00) begin errors++; $display("FAIL reset_rdata5 got %h exp 00", rdata5); end
        idle();
        evt0 = 2'b01;
        tick();
        evt0 = '0;
        checks++; if (flag0 !== 2'b01) begin errors++; $display("FAIL post_reset_evt got %b exp 01", flag0); end
        checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL post_reset_ack got %b exp 01", ack0); end
    endtask

    task automatic test_evt_irq;
        do_reset();
        bus_wr(R_IE, 8'h01);
        evt0 = 2'b01;
        tick();
        evt0 = '0;
        checks++; if (flag0 !== 2'b01) begin errors++; $display("FAIL evt_flag got %b exp 01", flag0); end
        checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL evt_ack got %b exp 01", ack0); end
        tick();
        checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL evt_ack_drop got %b exp 00", ack0); end
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq0); end
        bus_wr(R_STS, 8'hFE);
        checks++; if (flag0 !== 2'b00) begin errors++; $display("FAIL sts_clear got %b exp 00", flag0); end
        tick();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq0); end
    endtask

    task automatic test_evt_vs_clear;
        do_reset();
        evt0 = 2'b01;
        tick();
        evt0 = 2'b01;
        bus_wr(R_STS, 8'hFE);
        evt0 = '0;
        checks++; if (flag0 !== 2'b01) begin errors++; $display("FAIL evt_wins_clear got %b exp 01", flag0); end
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL no_ovr_on_clear got %h exp 00", rdata0); end
        idle();
    endtask

    task automatic test_overrun;
        evt0 = 2'b01;
        tick();
        evt0 = '0;
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata0 !== 8'h01) begin errors++; $display("FAIL ovr_set got %h exp 01", rdata0); end
        idle();
        bus_wr(R_OVR, 8'h00);
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL ovr_clr_m0 got %h exp 00", rdata0); end
        idle();
    endtask

    task automatic test_back_to_back;
        do_reset();
        evt1 = 2'b01;
        tick();
        checks++; if (ack1 !== 2'b01) begin errors++; $display("FAIL b2b_ack1 got %b exp 01", ack1); end
        tick();
        evt1 = '0;
        checks++; if (ack1 !== 2'b01) begin errors++; $display("FAIL b2b_ack2 got %b exp 01", ack1); end
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata1 !== 8'h01) begin errors++; $display("FAIL ovr_set_m1 got %h exp 01", rdata1); end
        idle();
        bus_wr(R_OVR, 8'h00);
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata1 !== 8'h01) begin errors++; $display("FAIL ovr_w0_m1 got %h exp 01", rdata1); end
        idle();
        bus_wr(R_OVR, 8'h01);
        rd_set(R_OVR, 1'b1);
        checks++; if (rdata1 !== 8'h00) begin errors++; $display("FAIL ovr_w1c_m1 got %h exp 00", rdata1); end
        idle();
        bus_wr(R_STS, 8'h01);
        checks++; if (flag1 !== 2'b00) begin errors++; $display("FAIL sts_w1c_m1 got %b exp 00", flag1); end
    endtask

    task automatic test_qualifiers;
        do_reset();
        evt0 = 2'b10;
        tick();
        evt0 = '0;
        bus_wr_q(R_STS, 8'hFD, 1'b1, 1'b1, 1'b0);
        checks++; if (flag0 !== 2'b10) begin errors++; $display("FAIL wr_not_ready got %b exp 10", flag0); end
        bus_wr_q(R_STS, 8'hFD, 1'b1, 1'b0, 1'b1);
        checks++; if (flag0 !== 2'b10) begin errors++; $display("FAIL wr_no_enable got %b exp 10", flag0); end
        bus_wr_q(R_STS, 8'hFD, 1'b0, 1'b1, 1'b1);
        checks++; if (flag0 !== 2'b10) begin errors++; $display("FAIL wr_no_sel got %b exp 10", flag0); end
        rd_set(R_STS, 1'b0);
        checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL rd_not_ready got %h exp 00", rdata0); end
        idle();
        rd_set(R_STS, 1'b1);
        checks++; if (rdata0 !== 8'h02) begin errors++; $display("FAIL rd_sts got %h exp 02", rdata0); end
        idle();
        bus_wr(R_STS, 8'hFD);
        checks++; if (flag0 !== 2'b00) begin errors++; $display("FAIL wr_clear_b1 got %b exp 00", flag0); end
        bus_wr(R_STS, 8'hFF);
        checks++; if (flag0 !== 2'b00) begin errors++; $display("FAIL no_sw_set got %b exp 00", flag0); end
    endtask

    task automatic test_width;
        do_reset();
        evt5 = 5'b10100;
        tick();
        evt5 = '0;
        checks++; if (flag5 !== 5'b10100) begin errors++; $display("FAIL w5_flag got %b exp 10100", flag5); end
        rd_set(R_STS, 1'b1);
        checks++; if (rdata5 !== 8'h14) begin errors++; $display("FAIL w5_rd_sts got %h exp 14", rdata5); end
        idle();
        checks++; if (irq5 !== 1'b0) begin errors++; $display("FAIL w5_irq_masked got %b exp 0", irq5); end
        bus_wr(R_IE, 8'hFF);
        rd_set(R_IE, 1'b1);
        checks++; if (rdata5 !== 8'h1F) begin errors++; $display("FAIL w5_rd_ie got %h exp 1f", rdata5); end
        idle();
        rd_set(R_STS | R_OVR, 1'b1);
        checks++; if (rdata5 !== 8'h14) begin errors++; $display("FAIL w5_rd_or got %h exp 14", rdata5); end
        idle();
        tick();
        checks++; if (irq5 !== 1'b1) begin errors++; $display("FAIL w5_irq got %b exp 1", irq5); end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        evt0 = '0; evt1 = '0; evt5 = '0;
        tick();
        test_reset();
        test_evt_irq();
        test_evt_vs_clear();
        test_overrun();
        test_back_to_back();
        test_qualifiers();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
